tcdm_rr_arbiter: RTL
====================

// Module: tcdm_rr_arbiter
// PURPOSE
// Shares one single-ported, fixed-latency TCDM slave among NB_MASTERS requesters.
// Fair round-robin arbitration; full throughput of one transaction per cycle.
// Routes each response back to the master that issued the request.
// Checks the slave's 1-cycle response latency; a missing response becomes an error reply.
// Sits between SoC-side TCDM masters and a memory/peripheral/error slave.
// PARAMETERS
// NB_MASTERS     4             number of requesters, >=1
// ADDR_WIDTH     32            address width
// DATA_WIDTH     32            data width
// BE_WIDTH       DATA_WIDTH/8  byte-enable width
// ERROR_RESPONSE 32'hBADACCE5  rdata returned on a missing slave response
// PORTS
// clk_i        in   1                      clock, all state on rising edge
// rst_i        in   1                      synchronous reset, active-high
// m_req_i      in   NB_MASTERS             per-master request
// m_add_i      in   NB_MASTERS x ADDR_WIDTH per-master address
// m_wen_i      in   NB_MASTERS             1=read, 0=write
// m_wdata_i    in   NB_MASTERS x DATA_WIDTH per-master write data
// m_be_i       in   NB_MASTERS x BE_WIDTH  per-master byte enables
// m_gnt_o      out  NB_MASTERS             per-master grant, one-hot or zero
// m_r_valid_o  out  NB_MASTERS             per-master response valid, one-hot or zero
// m_r_rdata_o  out  DATA_WIDTH            response data, shared by all masters
// m_r_opc_o    out  1                      response error flag, shared
// s_req_o/s_add_o/s_wen_o/s_wdata_o/s_be_o  out                 request to slave
// s_gnt_i      in   1                      slave grant
// s_r_valid_i  in   1                      slave response valid
// s_r_rdata_i  in   DATA_WIDTH            slave response data
// s_r_opc_i    in   1                      slave response error
// err_clr_i    in   1                      clears err_o
// err_o        out  1                      sticky protocol-error flag
// BEHAVIOUR
// - State
//   - rr_ptr_q: width max(1,$clog2(NB_MASTERS))
//   - rsp_pend_q, rsp_id_q, err_q
//   - Reset: all zero, so m_r_valid_o=0 and err_o=0 in the first cycle after reset.
// - Winner selection (combinational)
//   - Winner is the first set m_req_i bit at index >= rr_ptr_q, wrapping NB_MASTERS-1 -> 0.
//   - s_req_o = |m_req_i. s_add/wen/wdata/be_o = winner's fields.
//   - With no request, the slave request fields are all 0.
// - Grant (combinational)
//   - m_gnt_o[winner] = s_gnt_i & s_req_o. All other grants are 0.
//   - No request-to-grant latency; masters hold their request until granted.
// - Handshake = s_req_o & s_gnt_i
//   - rr_ptr_q <= (winner==NB_MASTERS-1) ? 0 : winner+1.
//   - Without a handshake, rr_ptr_q holds.
// - Response routing
//   - On a handshake: rsp_pend_q<=1, rsp_id_q<=winner. Otherwise rsp_pend_q<=0.
//   - Reads and writes are both acknowledged.
//   - Cycle after the handshake: m_r_valid_o[rsp_id_q]=1.
//   - With s_r_valid_i=1: rdata=s_r_rdata_i, opc=s_r_opc_i.
//   - With s_r_valid_i=0 (missing response): rdata=ERROR_RESPONSE, opc=1, err_q<=1.
//   - When rsp_pend_q=0: m_r_rdata_o=0 and m_r_opc_o=0.
//   - A spurious s_r_valid_i with rsp_pend_q=0 is dropped (no m_r_valid_o) and sets err_q<=1.
// - Back-to-back
//   - A new handshake may coincide with the response cycle of the previous one.
//   - No bubbles.
// - err_o
//   - err_o = err_q, sticky.
//   - err_clr_i clears it next cycle; a set condition in the same cycle wins over clear.
// - Reset mid-operation
//   - A pending response is discarded; no m_r_valid_o after reset.
//   - rr_ptr_q returns to 0.
// - NB_MASTERS=1
//   - Pointer is constant 0; the block reduces to a pass-through plus the latency check.
// TESTING
// 1. m_req_i=4'b1111 held, s_gnt_i=1 -> grants m0,m1,m2,m3,m0 on successive cycles;
//    each m_r_valid_o one cycle later on the same index.
// 2. m_req_i=4'b1010, rr_ptr_q=2 -> grant m3, then m1, then m3 (wrap-around).
// 3. m2 requests, s_gnt_i=0 for 3 cycles -> m_gnt_o=0 and ptr held;
//    s_gnt_i=1 on cycle 4 -> m_gnt_o=4'b0100, ptr=3.
// 4. Read granted to m1, slave gives no s_r_valid_i -> m_r_valid_o=4'b0010,
//    rdata=32'hBADACCE5, opc=1, err_o=1 until err_clr_i pulse.
// 5. Handshake, then rst_i=1 next cycle -> no m_r_valid_o; rr_ptr_q=0; err_o=0.
// 6. s_r_valid_i=1 with no pending request -> m_r_valid_o=0, err_o=1 next cycle;
//    err_clr_i together with a new error -> err_o stays 1.

Source files
------------

// File: rtl/tcdm_rr_arbiter.sv
// Round-robin arbiter sharing one single-ported, 1-cycle-latency TCDM slave among
// several masters, with response routing and a sticky response-latency error flag.
module tcdm_rr_arbiter #(
   parameter int unsigned           NB_MASTERS     = 4,
   parameter int unsigned           ADDR_WIDTH     = 32,
   parameter int unsigned           DATA_WIDTH     = 32,
   parameter int unsigned           BE_WIDTH       = DATA_WIDTH / 8,
   parameter logic [DATA_WIDTH-1:0] ERROR_RESPONSE = 32'hBADACCE5
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   // master side
   input  logic [NB_MASTERS-1:0]                 m_req_i,
   input  logic [NB_MASTERS-1:0][ADDR_WIDTH-1:0] m_add_i,
   input  logic [NB_MASTERS-1:0]                 m_wen_i,
   input  logic [NB_MASTERS-1:0][DATA_WIDTH-1:0] m_wdata_i,
   input  logic [NB_MASTERS-1:0][BE_WIDTH-1:0]   m_be_i,
   output logic [NB_MASTERS-1:0]                 m_gnt_o,
   output logic [NB_MASTERS-1:0]                 m_r_valid_o,
   output logic [DATA_WIDTH-1:0]                 m_r_rdata_o,
   output logic                                  m_r_opc_o,
   // slave side
   output logic                                  s_req_o,
   output logic [ADDR_WIDTH-1:0]                 s_add_o,
   output logic                                  s_wen_o,
   output logic [DATA_WIDTH-1:0]                 s_wdata_o,
   output logic [BE_WIDTH-1:0]                   s_be_o,
   input  logic                                  s_gnt_i,
   input  logic                                  s_r_valid_i,
   input  logic [DATA_WIDTH-1:0]                 s_r_rdata_i,
   input  logic                                  s_r_opc_i,
   // error reporting
   input  logic                                  err_clr_i,
   output logic                                  err_o
);

   localparam int unsigned PTR_W = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;

   logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic                  rsp_pend_q;
   logic [PTR_W-1:0]      rsp_id_q;
   logic                  err_q, err_d;

   logic [NB_MASTERS-1:0] upper_mask;
   logic [NB_MASTERS-1:0] req_upper;
   logic [NB_MASTERS-1:0] req_pick;
   logic                  win_any;
   logic [PTR_W-1:0]      win_idx;
   logic                  handshake;
   logic                  err_set;

   // Requests at or above the pointer take precedence; otherwise wrap to the lowest.
   genvar gi;
   generate
      for (gi = 0; gi < NB_MASTERS; gi++) begin : g_mask
         assign upper_mask[gi] = (int'(rr_ptr_q) <= gi);
      end
   endgenerate

   assign req_upper = m_req_i & upper_mask;
   assign req_pick  = (|req_upper) ? req_upper : m_req_i;
   assign win_any   = |m_req_i;

   always_comb begin
      win_idx = '0;
      for (int i = NB_MASTERS - 1; i >= 0; i--) begin
         if (req_pick[i]) begin
            win_idx = PTR_W'(i);
         end
      end
   end

   always_comb begin
      s_req_o   = win_any;
      s_add_o   = '0;
      s_wen_o   = 1'b0;
      s_wdata_o = '0;
      s_be_o    = '0;
      if (win_any) begin
         s_add_o   = m_add_i[win_idx];
         s_wen_o   = m_wen_i[win_idx];
         s_wdata_o = m_wdata_i[win_idx];
         s_be_o    = m_be_i[win_idx];
      end
   end

   assign handshake = win_any & s_gnt_i;

   // The response side is silenced while reset is asserted so a discarded
   // transaction never shows up as a valid response.
   generate
      for (gi = 0; gi < NB_MASTERS; gi++) begin : g_route
         assign m_gnt_o[gi]     = handshake & (win_idx == PTR_W'(gi));
         assign m_r_valid_o[gi] = rsp_pend_q & ~rst_i & (rsp_id_q == PTR_W'(gi));
      end
   endgenerate

   always_comb begin
      m_r_rdata_o = '0;
      m_r_opc_o   = 1'b0;
      if (rsp_pend_q && !rst_i) begin
         if (s_r_valid_i) begin
            m_r_rdata_o = s_r_rdata_i;
            m_r_opc_o   = s_r_opc_i;
         end else begin
            m_r_rdata_o = ERROR_RESPONSE;
            m_r_opc_o   = 1'b1;
         end
      end
   end

   generate
      if (NB_MASTERS == 1) begin : g_ptr_single
         assign rr_ptr_d = '0;
      end else begin : g_ptr_multi
         always_comb begin
            rr_ptr_d = rr_ptr_q;
            if (handshake) begin
               rr_ptr_d = (win_idx == PTR_W'(NB_MASTERS - 1)) ? '0 : win_idx + 1'b1;
            end
         end
      end
   endgenerate

   // A missing response or a response nobody asked for both flag an error; set beats clear.
   assign err_set = rsp_pend_q ^ s_r_valid_i;

   always_comb begin
      err_d = err_q;
      if (err_set) begin
         err_d = 1'b1;
      end else if (err_clr_i) begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_q   <= '0;
         rsp_pend_q <= 1'b0;
         rsp_id_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         rsp_pend_q <= handshake;
         if (handshake) begin
            rsp_id_q <= win_idx;
         end
         err_q      <= err_d;
      end
   end

   assign err_o = err_q;

endmodule
